// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first, and
// presents the registered difference with borrow, overflow and zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic a_bit, b_bit, diff_bit, br_next;

  // On the last edge the shift registers hold the original sign bits in bit 0,
  // so overflow can be judged without keeping a separate copy of the operands.
  assign a_bit    = a_sh_q[0];
  assign b_bit    = b_sh_q[0];
  assign diff_bit = a_bit ^ b_bit ^ br_q;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    f_d     = f_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = diff_bit;
        br_d              = br_next;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          f_d     = res_d;
          bout_d  = br_next;
          ovf_d   = (a_bit != b_bit) && (diff_bit != a_bit);
          zero_d  = (res_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      f_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      f_q     <= f_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign f    = f_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking new valid results.
REQ-009 SHALL have port f  output  WIDTH  registered difference a-b, modulo 2^WIDTH.
REQ-010 SHALL have port bout  output  1  borrow out; high when a<b unsigned.
REQ-011 SHALL have port ovf  output  1  two's-complement overflow of a-b.
REQ-012 SHALL have port zero  output  1  high when f is all zeros.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE with start=1 at edge k, capture a and b into internal shift registers, clear the internal borrow and bit counter, and enter SHIFT.
REQ-015 SHALL, in SHIFT, process one bit per edge LSB-first: d=a_i^b_i^br; br'=(~a_i&b_i)|(~(a_i^b_i)&br); d shifts into the MSB of a partial-result register.
REQ-016 SHALL leave SHIFT after exactly WIDTH processing edges (k+1..k+WIDTH); at edge k+WIDTH it loads f, bout=final br, ovf and zero, and enters DONE.
REQ-017 SHALL assert busy from after edge k until after edge k+WIDTH, i.e. exactly while in SHIFT.
REQ-018 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE at edge k+WIDTH+1.
REQ-019 SHALL compute ovf as (a[WIDTH-1]!=b[WIDTH-1]) && (f[WIDTH-1]!=a[WIDTH-1]) using the captured operands.
REQ-020 SHALL hold f, bout, ovf and zero stable from the DONE load until the next DONE load; partial results are never visible on f.
REQ-021 SHALL ignore start while in SHIFT or DONE; changes on a or b after capture do not affect the result.
REQ-022 SHALL accept start in the first IDLE cycle after DONE, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-023 SHALL treat start=1 held continuously as repeated requests, each accepted in IDLE.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force state=IDLE, busy=0, done=0, f=0, bout=0, ovf=0, zero=1, counter and borrow=0.
REQ-025 SHALL abort any in-progress operation on reset, with no done pulse and no change to outputs other than their reset values.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-027 SHALL pass the following test: with WIDTH=8, a=0x0C, b=0x03 and start pulsed, done occurs 8 edges after acceptance with f=0x09 and bout=ovf=zero=0.
REQ-028 SHALL pass the following test: a=0x03, b=0x0C produces f=0xF7, bout=1, ovf=0 and zero=0.
REQ-029 SHALL pass the following test: a=0x80, b=0x01 produces f=0x7F, bout=0 and ovf=1; a=0x7F, b=0xFF produces f=0x80, bout=1 and ovf=1.
REQ-030 SHALL pass the following test: a=b=0x5A produces f=0x00, zero=1 and bout=0.
REQ-031 SHALL pass the following test: start re-pulsed with new a and b mid-SHIFT is ignored, the first result is unchanged, and busy stays high for 8 cycles only.
REQ-032 SHALL pass the following test: rst_n pulsed low asynchronously mid-SHIFT drops busy immediately, produces no done pulse, gives f=0 and zero=1, and a following start computes correctly.
